// File: rtl/rggen_register_host.sv
// rggen_register_host: single-outstanding command-to-register bridge (IDLE -> ACCESS -> RESPOND).
// Define RGGEN_REGISTER_HOST_TIMEOUT_EN to abort stalled accesses after TIMEOUT_CYCLES with SLVERR.
module rggen_register_host #(
   parameter int ADDRESS_WIDTH  = 16,
   parameter int BUS_WIDTH      = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_cmd_valid,
   output logic                       o_cmd_ready,
   input  logic [ADDRESS_WIDTH-1:0]   i_cmd_address,
   input  logic                       i_cmd_write,
   input  logic [BUS_WIDTH-1:0]       i_cmd_write_data,
   input  logic [BUS_WIDTH/8-1:0]     i_cmd_strobe,
   output logic                       o_rsp_valid,
   input  logic                       i_rsp_ready,
   output logic [1:0]                 o_rsp_status,
   output logic [BUS_WIDTH-1:0]       o_rsp_read_data,
   output logic                       o_reg_valid,
   output logic [ADDRESS_WIDTH-1:0]   o_reg_address,
   output logic                       o_reg_write,
   output logic [BUS_WIDTH-1:0]       o_reg_write_data,
   output logic [BUS_WIDTH/8-1:0]     o_reg_strobe,
   input  logic                       i_reg_ready,
   input  logic [1:0]                 i_reg_status,
   input  logic [BUS_WIDTH-1:0]       i_reg_read_data
);
   localparam int         STROBE_WIDTH  = BUS_WIDTH / 8;
   localparam logic [1:0] STATUS_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      RESPOND = 2'd2
   } state_e;

   state_e                    r_state;
   state_e                    w_next_state;
   logic [ADDRESS_WIDTH-1:0]  r_address;
   logic                      r_write;
   logic [BUS_WIDTH-1:0]      r_write_data;
   logic [STROBE_WIDTH-1:0]   r_strobe;
   logic [1:0]                r_status;
   logic [BUS_WIDTH-1:0]      r_read_data;
   logic                      w_accept;
   logic                      w_complete;
   logic                      w_abort;
   logic                      w_timeout_hit;

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must lie in 1..65535");
   end

`ifdef RGGEN_REGISTER_HOST_TIMEOUT_EN
   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] r_wait_count;

   // Counts stalled ACCESS cycles; the cycle that would bring it to TIMEOUT_CYCLES aborts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wait_count <= '0;
      end else if (w_accept) begin
         r_wait_count <= '0;
      end else if (r_state == ACCESS && !i_reg_ready) begin
         r_wait_count <= r_wait_count + 16'd1;
      end
   end

   assign w_timeout_hit = (r_wait_count == TIMEOUT_LAST);
`else
   assign w_timeout_hit = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_complete   = 1'b0;
      w_abort      = 1'b0;
      o_cmd_ready  = 1'b0;
      o_reg_valid  = 1'b0;
      o_rsp_valid  = 1'b0;
      unique case (r_state)
         IDLE: begin
            o_cmd_ready = 1'b1;
            if (i_cmd_valid) begin
               w_accept     = 1'b1;
               w_next_state = ACCESS;
            end
         end
         ACCESS: begin
            o_reg_valid = 1'b1;
            if (i_reg_ready) begin
               w_complete   = 1'b1;
               w_next_state = RESPOND;
            end else if (w_timeout_hit) begin
               w_abort      = 1'b1;
               w_next_state = RESPOND;
            end
         end
         RESPOND: begin
            o_rsp_valid = 1'b1;
            if (i_rsp_ready) begin
               w_next_state = IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_address    <= '0;
         r_write      <= 1'b0;
         r_write_data <= '0;
         r_strobe     <= '0;
         r_status     <= '0;
         r_read_data  <= '0;
      end else begin
         if (w_accept) begin
            r_address    <= i_cmd_address;
            r_write      <= i_cmd_write;
            r_write_data <= i_cmd_write_data;
            r_strobe     <= i_cmd_strobe;
         end
         if (w_complete) begin
            r_status    <= i_reg_status;
            r_read_data <= r_write ? '0 : i_reg_read_data;
         end else if (w_abort) begin
            r_status    <= STATUS_SLVERR;
            r_read_data <= '0;
         end
      end
   end

   assign o_reg_address    = r_address;
   assign o_reg_write      = r_write;
   assign o_reg_write_data = r_write_data;
   assign o_reg_strobe     = r_strobe;
   assign o_rsp_status     = r_status;
   assign o_rsp_read_data  = r_read_data;

endmodule

// File: tb/tb_rggen_register_host.sv
// Self-checking bench for rggen_register_host: directed scenarios plus randomized transactions
// compared against a transaction-level model of the expected access length and response.
module tb_rggen_register_host;
   localparam int AW = 16;
   localparam int BW = 32;
   localparam int SW = BW / 8;
   localparam int TO = 8;
`ifdef RGGEN_REGISTER_HOST_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          i_cmd_valid = 1'b0;
   logic          o_cmd_ready;
   logic [AW-1:0] i_cmd_address = '0;
   logic          i_cmd_write = 1'b0;
   logic [BW-1:0] i_cmd_write_data = '0;
   logic [SW-1:0] i_cmd_strobe = '0;
   logic          o_rsp_valid;
   logic          i_rsp_ready = 1'b0;
   logic [1:0]    o_rsp_status;
   logic [BW-1:0] o_rsp_read_data;
   logic          o_reg_valid;
   logic [AW-1:0] o_reg_address;
   logic          o_reg_write;
   logic [BW-1:0] o_reg_write_data;
   logic [SW-1:0] o_reg_strobe;
   logic          i_reg_ready = 1'b0;
   logic [1:0]    i_reg_status = '0;
   logic [BW-1:0] i_reg_read_data = '0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   rggen_register_host #(
      .ADDRESS_WIDTH (AW),
      .BUS_WIDTH     (BW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .i_cmd_valid     (i_cmd_valid),
      .o_cmd_ready     (o_cmd_ready),
      .i_cmd_address   (i_cmd_address),
      .i_cmd_write     (i_cmd_write),
      .i_cmd_write_data(i_cmd_write_data),
      .i_cmd_strobe    (i_cmd_strobe),
      .o_rsp_valid     (o_rsp_valid),
      .i_rsp_ready     (i_rsp_ready),
      .o_rsp_status    (o_rsp_status),
      .o_rsp_read_data (o_rsp_read_data),
      .o_reg_valid     (o_reg_valid),
      .o_reg_address   (o_reg_address),
      .o_reg_write     (o_reg_write),
      .o_reg_write_data(o_reg_write_data),
      .o_reg_strobe    (o_reg_strobe),
      .i_reg_ready     (i_reg_ready),
      .i_reg_status    (i_reg_status),
      .i_reg_read_data (i_reg_read_data)
   );

   typedef struct {
      int            reg_cycles;   // cycles with o_reg_valid high
      bit            access_ok;    // o_reg_* held the command, no rsp overlap
      bit            rsp_prompt;   // response valid on the cycle right after access
      logic [1:0]    st;
      logic [BW-1:0] data;
      int            rsp_cycles;   // cycles with o_rsp_valid high
      bit            rsp_stable;   // status/data held, no reg overlap
      bit            busy_ok;      // o_cmd_ready low through access and response
   } obs_t;

   // Issues one command and plays the register and response sides; inputs change on negedges.
   task automatic do_txn(input logic [AW-1:0] addr, input logic wr, input logic [BW-1:0] wdata,
                         input logic [SW-1:0] strb, input int wait_cyc, input logic [1:0] st,
                         input logic [BW-1:0] rdata, input int rsp_delay, output obs_t o);
      int guard = 0;
      @(negedge clk);
      i_cmd_valid = 1'b1; i_cmd_address = addr; i_cmd_write = wr;
      i_cmd_write_data = wdata; i_cmd_strobe = strb;
      @(negedge clk);
      i_cmd_valid = 1'b0; i_cmd_address = AW'($urandom()); i_cmd_write = ~wr;
      i_cmd_write_data = $urandom(); i_cmd_strobe = SW'($urandom());
      o.reg_cycles = 0; o.access_ok = 1'b1; o.busy_ok = 1'b1;
      while (o_reg_valid === 1'b1 && guard < 300) begin
         o.reg_cycles++; guard++;
         if (o_reg_address !== addr || o_reg_write !== wr || o_reg_write_data !== wdata ||
             o_reg_strobe !== strb || o_rsp_valid !== 1'b0) o.access_ok = 1'b0;
         if (o_cmd_ready !== 1'b0) o.busy_ok = 1'b0;
         i_rsp_ready = 1'b1;  // stray, must be ignored
         i_reg_ready = (o.reg_cycles == wait_cyc + 1);
         i_reg_status    = i_reg_ready ? st : 2'($urandom());
         i_reg_read_data = i_reg_ready ? rdata : $urandom();
         @(negedge clk);
      end
      i_rsp_ready = 1'b0;
      i_reg_ready = 1'b1;  // stray, must be ignored
      i_reg_status = 2'($urandom()); i_reg_read_data = $urandom();
      o.rsp_prompt = (o_rsp_valid === 1'b1);
      o.st = o_rsp_status; o.data = o_rsp_read_data;
      o.rsp_cycles = 0; o.rsp_stable = 1'b1;
      while (o_rsp_valid === 1'b1 && guard < 600) begin
         o.rsp_cycles++; guard++;
         if (o_rsp_status !== o.st || o_rsp_read_data !== o.data || o_reg_valid !== 1'b0)
            o.rsp_stable = 1'b0;
         if (o_cmd_ready !== 1'b0) o.busy_ok = 1'b0;
         i_rsp_ready = (o.rsp_cycles == rsp_delay + 1);
         @(negedge clk);
      end
      i_rsp_ready = 1'b0; i_reg_ready = 1'b0;
      if (o_cmd_ready !== 1'b1) o.busy_ok = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if (o_reg_valid !== 1'b0 || o_rsp_valid !== 1'b0) begin
         bad++; $display("FAIL reset_valids: reg_valid=%b rsp_valid=%b want 0 0", o_reg_valid, o_rsp_valid);
      end
      total++;
      if (o_reg_address !== '0 || o_reg_write !== 1'b0 || o_reg_write_data !== '0 || o_reg_strobe !== '0) begin
         bad++; $display("FAIL reset_reg_fields: addr=%h wr=%b wd=%h strb=%h want zeros",
                         o_reg_address, o_reg_write, o_reg_write_data, o_reg_strobe);
      end
      total++;
      if (o_rsp_status !== 2'b00 || o_rsp_read_data !== '0) begin
         bad++; $display("FAIL reset_rsp_fields: st=%b data=%h want 00 0", o_rsp_status, o_rsp_read_data);
      end
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (o_cmd_ready !== 1'b1) begin
         bad++; $display("FAIL reset_cmd_ready: got %b want 1", o_cmd_ready);
      end
   endtask

   task automatic test_ignore_stray();
      bit ok = 1'b1;
      i_rsp_ready = 1'b1; i_reg_ready = 1'b1; i_reg_status = 2'b11; i_reg_read_data = 32'hFFFF_FFFF;
      repeat (3) begin
         @(negedge clk);
         if (o_cmd_ready !== 1'b1 || o_reg_valid !== 1'b0 || o_rsp_valid !== 1'b0) ok = 1'b0;
      end
      i_rsp_ready = 1'b0; i_reg_ready = 1'b0;
      total++;
      if (!ok) begin
         bad++; $display("FAIL idle_stray_ready: idle state disturbed got ok=%b want 1", ok);
      end
   endtask

   task automatic test_write_fast();
      obs_t o;
      do_txn(16'h0010, 1'b1, 32'hDEADBEEF, 4'hF, 0, 2'b00, 32'h1111_2222, 0, o);
      total++;
      if (o.reg_cycles !== 1 || !o.access_ok) begin
         bad++; $display("FAIL write_access: cycles=%0d fields_ok=%b want 1 1", o.reg_cycles, o.access_ok);
      end
      total++;
      if (!o.rsp_prompt || o.st !== 2'b00 || o.data !== 32'h0) begin
         bad++; $display("FAIL write_rsp: prompt=%b st=%b data=%h want 1 00 00000000", o.rsp_prompt, o.st, o.data);
      end
   endtask

   task automatic test_zero_strobe_write();
      obs_t o;
      do_txn(16'h0020, 1'b1, 32'hCAFE_0001, 4'h0, 1, 2'b01, 32'h0, 0, o);
      total++;
      if (o.reg_cycles !== 2 || !o.access_ok || o.st !== 2'b01 || o.data !== 32'h0) begin
         bad++; $display("FAIL zero_strobe: cycles=%0d ok=%b st=%b data=%h want 2 1 01 0",
                         o.reg_cycles, o.access_ok, o.st, o.data);
      end
   endtask

   task automatic test_read_wait();
      obs_t o;
      do_txn(16'h0004, 1'b0, 32'h0, 4'hF, 5, 2'b00, 32'h12345678, 0, o);
      total++;
      if (o.reg_cycles !== 6 || !o.access_ok) begin
         bad++; $display("FAIL read_wait_access: cycles=%0d ok=%b want 6 1", o.reg_cycles, o.access_ok);
      end
      total++;
      if (!o.rsp_prompt || o.st !== 2'b00 || o.data !== 32'h12345678) begin
         bad++; $display("FAIL read_wait_rsp: prompt=%b st=%b data=%h want 1 00 12345678", o.rsp_prompt, o.st, o.data);
      end
   endtask

   task automatic test_rsp_backpressure();
      obs_t o;
      do_txn(16'h0008, 1'b0, 32'h0, 4'h3, 2, 2'b01, 32'h0BAD_F00D, 4, o);
      total++;
      if (o.rsp_cycles !== 5 || !o.rsp_stable) begin
         bad++; $display("FAIL backpressure_hold: cycles=%0d stable=%b want 5 1", o.rsp_cycles, o.rsp_stable);
      end
      total++;
      if (!o.busy_ok || o.st !== 2'b01 || o.data !== 32'h0BAD_F00D) begin
         bad++; $display("FAIL backpressure_rsp: busy_ok=%b st=%b data=%h want 1 01 0badf00d", o.busy_ok, o.st, o.data);
      end
   endtask

   task automatic test_status_decerr();
      obs_t o;
      do_txn(16'h00FC, 1'b0, 32'h0, 4'hF, 1, 2'b11, 32'hA5A5A5A5, 1, o);
      total++;
      if (o.st !== 2'b11 || o.data !== 32'hA5A5A5A5) begin
         bad++; $display("FAIL decerr_rsp: st=%b data=%h want 11 a5a5a5a5", o.st, o.data);
      end
   endtask

`ifdef RGGEN_REGISTER_HOST_TIMEOUT_EN
   task automatic test_timeout();
      obs_t o;
      do_txn(16'h0100, 1'b0, 32'h0, 4'hF, 1000, 2'b00, 32'h5555_5555, 0, o);
      total++;
      if (o.reg_cycles !== TO || !o.access_ok) begin
         bad++; $display("FAIL timeout_access: cycles=%0d ok=%b want %0d 1", o.reg_cycles, o.access_ok, TO);
      end
      total++;
      if (!o.rsp_prompt || o.st !== 2'b10 || o.data !== 32'h0) begin
         bad++; $display("FAIL timeout_rsp: prompt=%b st=%b data=%h want 1 10 0", o.rsp_prompt, o.st, o.data);
      end
      // ready arriving on the last allowed cycle is a normal completion
      do_txn(16'h0104, 1'b0, 32'h0, 4'hF, TO - 1, 2'b01, 32'h7777_0000, 0, o);
      total++;
      if (o.reg_cycles !== TO || o.st !== 2'b01 || o.data !== 32'h7777_0000) begin
         bad++; $display("FAIL timeout_edge: cycles=%0d st=%b data=%h want %0d 01 77770000",
                         o.reg_cycles, o.st, o.data, TO);
      end
   endtask
`endif

   task automatic test_reset_in_access();
      obs_t o;
      bit quiet = 1'b1;
      @(negedge clk);
      i_cmd_valid = 1'b1; i_cmd_address = 16'h0040; i_cmd_write = 1'b1;
      i_cmd_write_data = 32'h0123_4567; i_cmd_strobe = 4'hF;
      @(negedge clk);
      i_cmd_valid = 1'b0;
      total++;
      if (o_reg_valid !== 1'b1) begin
         bad++; $display("FAIL rst_access_pre: reg_valid=%b want 1", o_reg_valid);
      end
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (o_reg_valid !== 1'b0 || o_rsp_valid !== 1'b0 || o_reg_address !== '0) begin
         bad++; $display("FAIL rst_access_drop: reg_valid=%b rsp_valid=%b addr=%h want 0 0 0",
                         o_reg_valid, o_rsp_valid, o_reg_address);
      end
      @(negedge clk);
      rst_n = 1'b1;
      i_reg_ready = 1'b1; i_rsp_ready = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (o_rsp_valid !== 1'b0 || o_reg_valid !== 1'b0 || o_cmd_ready !== 1'b1) quiet = 1'b0;
      end
      i_reg_ready = 1'b0; i_rsp_ready = 1'b0;
      total++;
      if (!quiet) begin
         bad++; $display("FAIL rst_access_no_rsp: quiet=%b want 1", quiet);
      end
      do_txn(16'h0044, 1'b0, 32'h0, 4'hC, 2, 2'b00, 32'hFEED_BEEF, 1, o);
      total++;
      if (o.reg_cycles !== 3 || !o.access_ok || o.st !== 2'b00 || o.data !== 32'hFEED_BEEF || !o.busy_ok) begin
         bad++; $display("FAIL rst_access_next: cycles=%0d ok=%b st=%b data=%h busy=%b want 3 1 00 feedbeef 1",
                         o.reg_cycles, o.access_ok, o.st, o.data, o.busy_ok);
      end
   endtask

   task automatic test_random();
      obs_t o;
      for (int i = 0; i < 40; i++) begin
         logic          wr    = 1'($urandom_range(0, 1));
         logic [AW-1:0] addr  = AW'($urandom());
         logic [BW-1:0] wdata = $urandom();
         logic [SW-1:0] strb  = SW'($urandom());
         int            wt    = int'($urandom_range(0, 12));
         logic [1:0]    st    = 2'($urandom());
         logic [BW-1:0] rdata = $urandom();
         int            dly   = int'($urandom_range(0, 3));
         bit            timed_out;
         int            exp_cycles;
         logic [1:0]    exp_st;
         logic [BW-1:0] exp_data;
         // model: ready comes on access cycle wt+1 unless the timeout limit ends the access first
         timed_out  = TO_EN && (wt + 1 > TO);
         exp_cycles = timed_out ? TO : wt + 1;
         exp_st     = timed_out ? 2'b10 : st;
         exp_data   = (timed_out || wr) ? '0 : rdata;
         do_txn(addr, wr, wdata, strb, wt, st, rdata, dly, o);
         total++;
         if (o.reg_cycles !== exp_cycles || !o.access_ok) begin
            bad++; $display("FAIL rand%0d_access: cycles=%0d ok=%b want %0d 1", i, o.reg_cycles, o.access_ok, exp_cycles);
         end
         total++;
         if (!o.rsp_prompt || o.st !== exp_st || o.data !== exp_data) begin
            bad++; $display("FAIL rand%0d_rsp: prompt=%b st=%b data=%h want 1 %b %h",
                            i, o.rsp_prompt, o.st, o.data, exp_st, exp_data);
         end
         total++;
         if (o.rsp_cycles !== dly + 1 || !o.rsp_stable || !o.busy_ok) begin
            bad++; $display("FAIL rand%0d_hold: cycles=%0d stable=%b busy=%b want %0d 1 1",
                            i, o.rsp_cycles, o.rsp_stable, o.busy_ok, dly + 1);
         end
      end
   endtask

   initial begin
      test_reset();
      test_ignore_stray();
      test_write_fast();
      test_zero_strobe_write();
      test_read_wait();
      test_rsp_backpressure();
      test_status_decerr();
`ifdef RGGEN_REGISTER_HOST_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_in_access();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
